uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// - Receive side of the board UART link: 8N1 serial bytes arriving on the rx pin go into a small FIFO.
// - The FIFO presents bytes through a valid/ready handshake to the core or a loader.
// - Complements the transmit path: host-to-board traffic, 16x oversampled.
// - Flags framing errors and FIFO overrun as one-cycle pulses.
//
// PARAMETERS
// - CLK_HZ      27_000_000  system clock frequency (Hz)
// - BAUD        115200      line rate
// - OVERSAMPLE  16          ticks per bit; must be even, >= 8
// - FIFO_DEPTH  16          byte entries; power of two, >= 2
//
// PORTS
// - clk         in   1      system clock, all logic on rising edge
// - reset       in   1      asynchronous, active-low reset
// - rx          in   1      async serial input, idle high
// - rx_data     out  8      FIFO head byte; valid only when rx_valid=1
// - rx_valid    out  1      FIFO not empty
// - rx_ready    in   1      consumer accepts head when rx_valid & rx_ready
// - frame_err   out  1      1-cycle pulse: stop bit sampled 0
// - overrun     out  1      1-cycle pulse: byte completed while FIFO full and no pop
// - fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
// - busy        out  1      receiver FSM not in IDLE
//
// BEHAVIOUR
// - Reset (reset=0, async):
//   - FSM=IDLE, FIFO empty, synchroniser flops=1, tick counter=0.
//   - rx_valid=0, rx_data=0, frame_err=0, overrun=0, fifo_count=0, busy=0.
// - Synchroniser: 2 flops on rx; all decisions use the 2nd flop (rxs).
// - Tick generator:
//   - DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), rounded.
//   - Free-running counter; 1-clk tick when it reaches DIV-1, then wraps to 0.
//   - Counter is restarted on IDLE->START so the first tick is phase-aligned.
// - FSM states IDLE, START, DATA, STOP, BREAK; ticks counted per bit by sub-counter sc:
//   - IDLE:  rxs=0 -> START, sc=0.
//   - START: at sc=OVERSAMPLE/2-1 sample rxs.
//     - rxs=1 -> IDLE (glitch; no flag).
//     - rxs=0 -> DATA, sc=0, bit index=0.
//   - DATA: sample every OVERSAMPLE ticks (mid-bit), LSB first into shift reg; after bit 7 -> STOP.
//   - STOP: at mid-bit sample rxs.
//     - rxs=1 -> push byte, -> IDLE.
//     - rxs=0 -> frame_err pulse, byte discarded, -> BREAK.
//   - BREAK: wait until rxs=1 (no tick needed), then -> IDLE. Handles held-low line / break.
// - FIFO:
//   - First-word fall-through: rx_data = head entry combinationally from storage; rx_valid = count!=0.
//   - Push takes effect on the stop-sample clock; rx_valid rises the following cycle when previously empty.
//   - Pop when rx_valid & rx_ready. Head advances next cycle; back-to-back pops every cycle allowed.
//   - Push and pop in the same cycle: both performed, count unchanged; legal even when full.
//   - Full & push & !pop: byte dropped, overrun pulses for that one clock, FIFO contents untouched.
//   - Empty & pop: impossible (rx_valid=0), ignored.
//   - Pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
// - Reset mid-frame aborts reception; no partial byte is ever pushed.
// - Latency: rx falling edge at stop-bit midpoint + 2 sync clocks + 1 clk -> rx_valid.
//
// STRUCTURE
// - Shared include uart_defs.vh:
//   - FSM state encodings.
//   - UART_DATA_BITS=8.
//   - Baud divisor macro, so the TX side computes an identical DIV.
// - Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): FWFT storage, pointers, count, full/empty.
// - The top of this file holds the synchroniser, tick generator, FSM and shift register.
//
// TESTING (bench clock 27 MHz, BAUD 115200, DIV=15, one bit = 240 clk)
// 1. Send 0x55 with rx_ready=0 -> rx_valid=1, rx_data=0x55, fifo_count=1; stop-mid + 3 clk; no flags.
// 2. rx low pulse for 4 ticks (60 clk) then high -> FSM returns IDLE, no push, frame_err=0.
// 3. Send 0xA3 with stop bit 0, line high 1 bit later -> frame_err one pulse, fifo_count stays 0,
//    next good byte 0x3C received correctly.
// 4. With rx_ready=0, send 17 bytes 0x00..0x10 -> fifo_count=16; overrun pulses once on 0x10;
//    then rx_ready=1 drains 0x00..0x0F in order on 16 consecutive clocks.
// 5. FIFO full; 17th byte completes on the same clock as a pop -> no overrun,
//    count stays 16, 0x10 is last out.
// 6. Assert reset during DATA bit 4 -> all outputs 0 immediately.
//    After release, a fresh 0xFF is received and no stale byte appears.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared definitions for the UART receive path.
//   DATA_BITS  - bits per character (8N1 framing)
//   rx_state_e - receiver FSM state encoding
//   baud_div() - rounded clock divider for the oversample tick; the TX side
//                imports the same function so both ends agree on the bit time.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    // Round to nearest: (clk + rate/2) / rate, where rate = baud * oversample.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned rate;
        rate = baud * oversample;
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream handshake out of the UART receiver.
//   rx_data  - head byte, meaningful only while rx_valid=1
//   rx_valid - a byte is available
//   rx_ready - consumer takes the head byte when rx_valid & rx_ready
// master = receiver (producer), slave = consumer.
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// uart_rx_fifo_sync_fifo: first-word fall-through FIFO.
//   clk, reset - clock, asynchronous active-low reset (clears storage too)
//   push/wdata - write request and data
//   pop        - read request; ignored while empty
//   rdata      - head entry, read combinationally from storage
//   empty      - no entries
//   overflow   - push refused because full with no simultaneous pop
//   count      - occupied entries, 0..DEPTH
// Push and pop in the same cycle are both performed, even when full.
module uart_rx_fifo_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // When full, a pop frees the slot the write pointer already points at.
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign rdata    = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver, 16x oversampled, feeding a FWFT byte FIFO.
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - asynchronous serial input, idle high
//   bus        - byte handshake (rx_data/rx_valid out, rx_ready in)
//   frame_err  - one-cycle pulse when the stop bit samples low
//   overrun    - one-cycle pulse when a byte completes into a full FIFO with no pop
//   fifo_count - occupied FIFO entries
//   busy       - receiver is inside a frame (FSM not idle)
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    uart_rx_fifo_if.master                bus,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0]  DIV_LAST = TW'(DIV - 1);
    localparam logic [SCW-1:0] SC_MID   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    // Two-flop synchroniser; only rxs is used downstream.
    logic rx_meta_q;
    logic rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs       <= rx_meta_q;
        end
    end

    // Oversample tick generator.
    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    logic          tick_restart;

    assign tick = (tick_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (tick_restart || tick) begin
            // Restart on the start edge so mid-bit samples sit on tick boundaries.
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Receiver FSM.
    rx_state_e            state_q, state_d;
    logic [SCW-1:0]       sc_q, sc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push;
    logic                 stop_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sc_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        tick_restart = 1'b0;
        push         = 1'b0;
        stop_bad     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d      = StStart;
                    sc_d         = '0;
                    tick_restart = 1'b1;
                end
            end

            StStart: begin
                if (tick) begin
                    if (sc_q == SC_MID) begin
                        if (rxs) begin
                            // Line went back high before mid start bit: a glitch.
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            sc_d    = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            StData: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            StStop: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        if (rxs) begin
                            push    = 1'b1;
                            state_d = StIdle;
                        end else begin
                            stop_bad = 1'b1;
                            state_d  = StBreak;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end

            StBreak: begin
                // Hold off until the line returns high so a break is one error.
                if (rxs) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Byte FIFO.
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_overflow;

    uart_rx_fifo_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wdata    (shreg_q),
        .pop      (bus.rx_ready),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .overflow (fifo_overflow),
        .count    (fifo_count)
    );

    assign bus.rx_data  = fifo_rdata;
    assign bus.rx_valid = ~fifo_empty;
    assign frame_err    = stop_bad;
    assign overrun      = fifo_overflow;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven frame vectors plus hand-written corner sequences,
// with a byte scoreboard checked on every accepted handshake.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 240;   // 27 MHz / 115200 with DIV=15, 16x oversample
    localparam int LAT      = 2283;  // start-bit drive -> rx_valid visible (stop mid + 3)

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       frame_err;
    logic       overrun;
    logic [4:0] fifo_count;
    logic       busy;

    uart_rx_fifo_if bus_if ();

    uart_rx_fifo #(
        .CLK_HZ     (27_000_000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .bus        (bus_if),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         npass = 0;
    int         ntot = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         rise_cyc = -1;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pop_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        int         exp_fe;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the rising edge.
    task automatic monitor();
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (bus_if.rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus_if.rx_valid;
        if (bus_if.rx_valid && bus_if.rx_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                ntot++;
                $display("FAIL pop_unexpected: got 0x%0h expected no pop", bus_if.rx_data);
            end else begin
                check("pop_data", int'(bus_if.rx_data), int'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Sends one frame; pop_at>0 raises rx_ready for exactly one cycle after that many clocks.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int pop_at, input int idle);
        logic [9:0] bits;
        int k;
        bits      = {stop, data, 1'b0};
        k         = 0;
        rise_cyc  = -1;
        start_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            for (int j = 0; j < BIT_CLKS; j++) begin
                step();
                k++;
                if (pop_at > 0 && k == pop_at) bus_if.rx_ready = 1'b1;
                else if (pop_at > 0 && k == pop_at + 1) bus_if.rx_ready = 1'b0;
            end
        end
        rx = 1'b1;
        for (int j = 0; j < idle; j++) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus_if.rx_ready = 1'b1;
        while (bus_if.rx_valid && n < 64) begin
            step();
            n++;
        end
        bus_if.rx_ready = 1'b0;
        check("drain_done", int'(bus_if.rx_valid), 0);
    endtask

    initial begin
        int fe0, ov0, pc0, lat;

        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_count: 1, exp_fe: 0, exp_lat: LAT};
        vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_count: 0, exp_fe: 1, exp_lat: -1};
        vecs[2] = '{data: 8'h3C, stop: 1'b1, exp_count: 1, exp_fe: 0, exp_lat: LAT};
        vecs[3] = '{data: 8'h01, stop: 1'b1, exp_count: 1, exp_fe: 0, exp_lat: LAT};
        vecs[4] = '{data: 8'h80, stop: 1'b1, exp_count: 1, exp_fe: 0, exp_lat: LAT};

        reset           = 1'b0;
        rx              = 1'b1;
        bus_if.rx_ready = 1'b0;
        #1;
        check("rst_valid", int'(bus_if.rx_valid), 0);
        check("rst_data", int'(bus_if.rx_data), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({frame_err, overrun}), 0);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Frame vectors, each starting from an empty FIFO.
        foreach (vecs[i]) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            if (vecs[i].exp_count != 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, 0, BIT_CLKS);
            lat = (rise_cyc < 0) ? -1 : rise_cyc - start_cyc;
            check("vec_count", int'(fifo_count), vecs[i].exp_count);
            check("vec_fe", fe_cnt - fe0, vecs[i].exp_fe);
            check("vec_ov", ov_cnt - ov0, 0);
            check("vec_latency", lat, vecs[i].exp_lat);
            check("vec_busy", int'(busy), 0);
            if (vecs[i].exp_count != 0) begin
                check("vec_head", int'(bus_if.rx_data), int'(vecs[i].data));
                drain();
            end
        end

        // Start-bit glitch of 4 ticks: back to idle with nothing pushed or flagged.
        fe0 = fe_cnt;
        rx  = 1'b0;
        for (int i = 0; i < 60; i++) step();
        rx = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("glitch_busy_mid", int'(busy), 1);
        for (int i = 0; i < 300; i++) step();
        check("glitch_busy_end", int'(busy), 0);
        check("glitch_count", int'(fifo_count), 0);
        check("glitch_fe", fe_cnt - fe0, 0);

        // Fill to full, then a push coinciding with a pop, then a true overrun.
        ov0 = ov_cnt;
        for (int b = 0; b < 16; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0, 0);
        end
        check("full_count", int'(fifo_count), 16);
        check("full_ov", ov_cnt - ov0, 0);

        pc0 = pop_cnt;
        exp_q.push_back(8'h10);
        send_frame(8'h10, 1'b1, LAT - 1, 0);
        check("pushpop_count", int'(fifo_count), 16);
        check("pushpop_ov", ov_cnt - ov0, 0);
        check("pushpop_pops", pop_cnt - pc0, 1);

        send_frame(8'h11, 1'b1, 0, BIT_CLKS);
        check("overrun_count", int'(fifo_count), 16);
        check("overrun_pulse", ov_cnt - ov0, 1);

        pc0 = pop_cnt;
        bus_if.rx_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("drain15_count", int'(fifo_count), 1);
        step();
        bus_if.rx_ready = 1'b0;
        check("drain16_count", int'(fifo_count), 0);
        check("drain16_pops", pop_cnt - pc0, 16);
        check("drain16_sb", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) step();

        // Reset during data bit 4 with a byte already queued.
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 0, BIT_CLKS);
        check("pre_rst_count", int'(fifo_count), 1);
        begin
            logic [7:0] d;
            d  = 8'hC3;
            rx = 1'b0;
            for (int j = 0; j < BIT_CLKS; j++) step();
            for (int b = 0; b < 4; b++) begin
                rx = d[b];
                for (int j = 0; j < BIT_CLKS; j++) step();
            end
            rx = d[4];
            for (int j = 0; j < 100; j++) step();
        end
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(bus_if.rx_valid), 0);
        check("mid_rst_data", int'(bus_if.rx_data), 0);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_flags", int'({frame_err, overrun}), 0);
        exp_q.delete();
        rx = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("post_rst_count", int'(fifo_count), 0);

        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 0, BIT_CLKS);
        check("post_rst_ff_count", int'(fifo_count), 1);
        check("post_rst_ff_head", int'(bus_if.rx_data), 8'hFF);
        drain();
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
